// File: rtl/cu_seq_ctrl.sv
// cu_seq_ctrl: parametrised instruction-sequencing control unit.
// Issues a one-cycle one-hot chip-select to each of N_STAGES units in order,
// waits for that unit's ready, pulses instr_done after the last stage, and
// stops at an instruction boundary when run drops. A per-stage watchdog parks
// the FSM in a sticky error state that only reset clears.
// Optional build macro: CU_PERF_CNT_EN adds instr_cnt_o and stall_cnt_o.
//
// state   | meaning
// S_IDLE  | no instruction in flight, waiting for run
// S_ISSUE | one cycle; registers cs for the current stage, clears watchdog
// S_WAIT  | cs pulse visible on entry, waiting for ready of current stage
// S_ERR   | watchdog expired; frozen until reset
//
// All outputs are registered, so the cs pulse set up in S_ISSUE is seen on
// the first S_WAIT cycle. This is what keeps instr_done (registered on ready
// acceptance) one cycle ahead of the following cs[0].
module cu_seq_ctrl #(
  parameter int N_STAGES = 4,
  parameter int TIMEOUT  = 64,
  parameter int TW       = 8,
  localparam int SW      = $clog2(N_STAGES)
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                run_i,
  input  logic [N_STAGES-1:0] ready_i,
  output logic [N_STAGES-1:0] cs_o,
  output logic                sel_fcu_o,
  output logic [SW-1:0]       stage_idx_o,
  output logic                busy_o,
  output logic                instr_done_o,
`ifdef CU_PERF_CNT_EN
  output logic [31:0]         instr_cnt_o,
  output logic [31:0]         stall_cnt_o,
`endif
  output logic                err_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_ERR   = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [SW-1:0]         stage_q, stage_d;
  logic [TW-1:0]         wd_q, wd_d;
  logic [N_STAGES-1:0]   cs_q, cs_d;
  logic                  sel_q, sel_d;
  logic                  done_q, done_d;
  logic                  busy_q, err_q;

  logic                  rdy_cur;
  logic                  last_stage;
  logic                  wd_expired;

  assign rdy_cur    = ready_i[stage_q];
  assign last_stage = (stage_q == SW'(N_STAGES - 1));
  // TIMEOUT = 0 disables the watchdog; the counter then just free-runs.
  assign wd_expired = (TIMEOUT != 0) && (wd_q == TW'(TIMEOUT - 1));

  // Next-state and next-output decode for the sequencer.
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    wd_d    = wd_q;
    cs_d    = '0;
    sel_d   = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (run_i) begin
          state_d = S_ISSUE;
          stage_d = '0;
        end
      end
      S_ISSUE: begin
        cs_d    = {{(N_STAGES-1){1'b0}}, 1'b1} << stage_q;
        sel_d   = (stage_q == '0);
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        wd_d = wd_q + TW'(1);
        if (rdy_cur) begin
          if (!last_stage) begin
            stage_d = stage_q + SW'(1);
            state_d = S_ISSUE;
          end else begin
            done_d  = 1'b1;
            stage_d = '0;
            state_d = run_i ? S_ISSUE : S_IDLE;
          end
        end else if (wd_expired) begin
          // stage_idx stays on the unit that failed to answer
          state_d = S_ERR;
        end
      end
      S_ERR: begin
        state_d = S_ERR;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      stage_q <= '0;
      wd_q    <= '0;
      cs_q    <= '0;
      sel_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      wd_q    <= wd_d;
      cs_q    <= cs_d;
      sel_q   <= sel_d;
      done_q  <= done_d;
      busy_q  <= (state_d == S_ISSUE) || (state_d == S_WAIT);
      err_q   <= (state_d == S_ERR);
    end
  end

  assign cs_o         = cs_q;
  assign sel_fcu_o    = sel_q;
  assign stage_idx_o  = stage_q;
  assign busy_o       = busy_q;
  assign instr_done_o = done_q;
  assign err_o        = err_q;

`ifdef CU_PERF_CNT_EN
  logic [31:0] icnt_q, scnt_q;

  // Instruction counter wraps; stall counter saturates.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      icnt_q <= '0;
      scnt_q <= '0;
    end else begin
      if (done_d) begin
        icnt_q <= icnt_q + 32'd1;
      end
      if ((state_q == S_WAIT) && !rdy_cur && (scnt_q != 32'hFFFF_FFFF)) begin
        scnt_q <= scnt_q + 32'd1;
      end
    end
  end

  assign instr_cnt_o = icnt_q;
  assign stall_cnt_o = scnt_q;
`endif

endmodule

// File: tb/tb_cu_seq_ctrl.sv
// Testbench for cu_seq_ctrl (N_STAGES=4, TIMEOUT=5).
// Inputs are driven and outputs sampled on the falling edge. Cycle u of a
// scenario is the u-th falling edge; what is driven at edge u is what the
// DUT samples on the following rising edge.
module tb_cu_seq_ctrl;
  localparam int N  = 4;
  localparam int TO = 5;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         run = 1'b0;
  logic [N-1:0] ready = '0;
  logic [N-1:0] cs;
  logic         sel_fcu;
  logic [1:0]   stage_idx;
  logic         busy;
  logic         instr_done;
  logic         err;
`ifdef CU_PERF_CNT_EN
  logic [31:0]  instr_cnt;
  logic [31:0]  stall_cnt;
  int unsigned  exp_icnt = 0;
  int unsigned  exp_scnt = 0;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cu_seq_ctrl #(.N_STAGES(N), .TIMEOUT(TO), .TW(8)) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .run_i        (run),
    .ready_i      (ready),
    .cs_o         (cs),
    .sel_fcu_o    (sel_fcu),
    .stage_idx_o  (stage_idx),
    .busy_o       (busy),
    .instr_done_o (instr_done),
`ifdef CU_PERF_CNT_EN
    .instr_cnt_o  (instr_cnt),
    .stall_cnt_o  (stall_cnt),
`endif
    .err_o        (err)
  );

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    run   = 1'b0;
    ready = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
`ifdef CU_PERF_CNT_EN
    exp_icnt = 0;
    exp_scnt = 0;
`endif
  endtask

  task automatic test_reset();
    checks++; if (cs !== '0) begin errors++; $display("FAIL reset_cs got %b want 0000", cs); end
    checks++; if (sel_fcu !== 1'b0) begin errors++; $display("FAIL reset_sel got %b want 0", sel_fcu); end
    checks++; if (stage_idx !== 2'd0) begin errors++; $display("FAIL reset_stage got %0d want 0", stage_idx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (instr_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", instr_done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
`ifdef CU_PERF_CNT_EN
    checks++; if (instr_cnt !== 32'd0) begin errors++; $display("FAIL reset_icnt got %0d want 0", instr_cnt); end
    checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL reset_scnt got %0d want 0", stall_cnt); end
`endif
  endtask

  // Reference timeline built from the timing rules: stage s issued at cycle t
  // shows cs at t+1, its ready arrives d cycles later at t+1+d, the next issue
  // is at t+2+d; after the last stage that cycle carries instr_done.
  // fixed_stall < 0 picks random stalls in 0..TO-1 (never enough to time out).
  // noise raises every ready bit in ISSUE cycles and every other bit while
  // waiting. run drops during the wait on stop_stage of the last instruction.
  task automatic test_seq(input string name, input int n_instr, input int fixed_stall,
                          input bit noise, input int stop_stage);
    logic [N-1:0] exp_cs [256];
    logic [N-1:0] drv_rdy [256];
    logic         exp_done [256];
    logic         exp_busy [256];
    logic         drv_run [256];
    logic [1:0]   exp_stage [256];
    int t, d, cut, len, tot_stall;
    for (int u = 0; u < 256; u++) begin
      exp_cs[u]    = '0;
      exp_done[u]  = 1'b0;
      exp_busy[u]  = 1'b0;
      exp_stage[u] = 2'd0;
      drv_run[u]   = 1'b1;
      drv_rdy[u]   = noise ? N'($urandom) : '0;
    end
    t = 1;
    cut = 1;
    tot_stall = 0;
    for (int i = 0; i < n_instr; i++) begin
      for (int s = 0; s < N; s++) begin
        d = (fixed_stall >= 0) ? fixed_stall : int'($urandom_range(0, TO - 1));
        tot_stall += d;
        if (noise) drv_rdy[t] = '1;
        for (int u = t; u <= t + 1 + d; u++) begin
          exp_stage[u] = 2'(s);
          exp_busy[u]  = 1'b1;
        end
        exp_cs[t + 1] = N'(1) << s;
        for (int u = t + 1; u <= t + d; u++) drv_rdy[u] = noise ? ~(N'(1) << s) : '0;
        drv_rdy[t + 1 + d] = noise ? '1 : (N'(1) << s);
        if (i == n_instr - 1 && s == stop_stage) cut = t + 1;
        t = t + 2 + d;
      end
      exp_done[t] = 1'b1;
    end
    for (int u = cut; u < 256; u++) drv_run[u] = 1'b0;
    len = t + 6;
    for (int u = 0; u < len; u++) begin
      @(negedge clk);
      checks++; if (cs !== exp_cs[u]) begin errors++; $display("FAIL %s cs t=%0d got %b want %b", name, u, cs, exp_cs[u]); end
      checks++; if (sel_fcu !== (exp_cs[u] == N'(1))) begin errors++; $display("FAIL %s sel_fcu t=%0d got %b want %b", name, u, sel_fcu, exp_cs[u] == N'(1)); end
      checks++; if (stage_idx !== exp_stage[u]) begin errors++; $display("FAIL %s stage_idx t=%0d got %0d want %0d", name, u, stage_idx, exp_stage[u]); end
      checks++; if (busy !== exp_busy[u]) begin errors++; $display("FAIL %s busy t=%0d got %b want %b", name, u, busy, exp_busy[u]); end
      checks++; if (instr_done !== exp_done[u]) begin errors++; $display("FAIL %s instr_done t=%0d got %b want %b", name, u, instr_done, exp_done[u]); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL %s err t=%0d got %b want 0", name, u, err); end
      run   = drv_run[u];
      ready = drv_rdy[u];
    end
    run   = 1'b0;
    ready = '0;
`ifdef CU_PERF_CNT_EN
    exp_icnt += n_instr;
    exp_scnt += tot_stall;
    checks++; if (instr_cnt !== exp_icnt) begin errors++; $display("FAIL %s instr_cnt got %0d want %0d", name, instr_cnt, exp_icnt); end
    checks++; if (stall_cnt !== exp_scnt) begin errors++; $display("FAIL %s stall_cnt got %0d want %0d", name, stall_cnt, exp_scnt); end
`endif
  endtask

  task automatic test_basic();
    test_seq("basic", 2, 0, 1'b0, N - 1);
  endtask

  task automatic test_stop_mid();
    test_seq("stop_mid", 1, -1, 1'b0, 2);
  endtask

  task automatic test_random();
    for (int k = 0; k < 5; k++) begin
      test_seq("random", int'($urandom_range(1, 3)), -1, 1'b0, int'($urandom_range(0, N - 1)));
    end
  endtask

  task automatic test_back_to_back();
    test_seq("b2b", 3, 0, 1'b0, N - 1);
  endtask

  task automatic test_wd_edge();
    test_seq("wd_edge", 1, TO - 1, 1'b0, N - 1);
  endtask

  task automatic test_spurious();
    test_seq("spurious", 2, -1, 1'b1, 1);
  endtask

  task automatic test_perf();
    test_seq("perf", 3, 2, 1'b0, N - 1);
  endtask

  // Stage 1 never answers: cs[1] visible at cycle 4, err expected at cycle 4+TO.
  task automatic test_watchdog();
    @(negedge clk); run = 1'b1; ready = '0;
    @(negedge clk);
    @(negedge clk); ready = 4'b0001;
    @(negedge clk); ready = '0;
    for (int u = 4; u < 4 + TO; u++) begin
      @(negedge clk);
      if (u == 4) begin
        checks++; if (cs !== 4'b0010) begin errors++; $display("FAIL wd cs1 got %b want 0010", cs); end
      end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL wd early_err t=%0d got %b want 0", u, err); end
    end
    @(negedge clk);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL wd err got %b want 1", err); end
    checks++; if (stage_idx !== 2'd1) begin errors++; $display("FAIL wd stage got %0d want 1", stage_idx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wd busy got %b want 0", busy); end
    ready = '1;
    for (int u = 0; u < 4; u++) begin
      @(negedge clk);
      checks++; if (cs !== '0) begin errors++; $display("FAIL wd cs_in_err got %b want 0000", cs); end
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL wd sticky got %b want 1", err); end
    end
    do_reset();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL wd err_after_reset got %b want 0", err); end
    checks++; if (stage_idx !== 2'd0) begin errors++; $display("FAIL wd stage_after_reset got %0d want 0", stage_idx); end
  endtask

  // Reset asserted while cs[1] is on the bus must clear everything at once.
  task automatic test_reset_mid();
    @(negedge clk); run = 1'b1; ready = '0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); ready = 4'b0001;
    @(negedge clk); ready = '0;
    @(negedge clk);
    checks++; if (cs !== 4'b0010) begin errors++; $display("FAIL rmid cs_before got %b want 0010", cs); end
`ifdef CU_PERF_CNT_EN
    checks++; if (stall_cnt !== 32'd1) begin errors++; $display("FAIL rmid scnt_before got %0d want 1", stall_cnt); end
`endif
    reset = 1'b1;
    #1;
    checks++; if (cs !== '0) begin errors++; $display("FAIL rmid cs got %b want 0000", cs); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid busy got %b want 0", busy); end
    checks++; if (stage_idx !== 2'd0) begin errors++; $display("FAIL rmid stage got %0d want 0", stage_idx); end
    checks++; if (sel_fcu !== 1'b0) begin errors++; $display("FAIL rmid sel got %b want 0", sel_fcu); end
`ifdef CU_PERF_CNT_EN
    checks++; if (instr_cnt !== 32'd0) begin errors++; $display("FAIL rmid icnt got %0d want 0", instr_cnt); end
    checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL rmid scnt got %0d want 0", stall_cnt); end
`endif
    do_reset();
  endtask

  initial begin
    do_reset();
    test_reset();
    test_basic();
    test_stop_mid();
    test_random();
    test_back_to_back();
    test_wd_edge();
    test_spurious();
    test_perf();
    test_watchdog();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
